// File: rtl/dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter
//
// Shares port 0 (1RW) of the user-project data SRAM (OpenRAM 32x256) between
// the rvj1 core data port (OBI-style) and the Caravel Wishbone slave port, so
// management firmware can preload and inspect data memory while the core runs.
// One SRAM access per cycle; round-robin on conflict.
//
// Ports:
//   clk_i, rstn_i        clock (shared with SRAM clk0), async active-low reset
//   core_*               OBI-style core data port: req/gnt in the access cycle,
//                        rvalid/rdata exactly one cycle after the grant
//   wbs_*                Wishbone classic slave (decoded upstream), byte address
//                        with bits [1:0] ignored; ack one cycle after the grant
//   sram_*               SRAM port 0: csb0, web0, wmask0, addr0, din0, dout0
//
// Handshake semantics: a core request is accepted in any cycle where
// core_req_i & core_gnt_o; the response follows one cycle later with
// core_rvalid_o (reads and writes alike). A Wishbone request (cyc & stb) is
// accepted in the cycle the SRAM is driven for it; wbs_ack_o is high for
// exactly the following cycle. A master dropping stb before its grant is not
// served and receives no ack.
// ---------------------------------------------------------------------------
module dram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  // core data port
  input  logic                   core_req_i,
  input  logic                   core_we_i,
  input  logic [DATA_W/8-1:0]    core_be_i,
  input  logic [ADDR_W-1:0]      core_addr_i,
  input  logic [DATA_W-1:0]      core_wdata_i,
  output logic                   core_gnt_o,
  output logic                   core_rvalid_o,
  output logic [DATA_W-1:0]      core_rdata_o,
  // wishbone slave
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [DATA_W/8-1:0]    wbs_sel_i,
  input  logic [ADDR_W+1:0]      wbs_adr_i,
  input  logic [DATA_W-1:0]      wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [DATA_W-1:0]      wbs_dat_o,
  // sram port 0
  output logic                   sram_csb0_o,
  output logic                   sram_web0_o,
  output logic [DATA_W/8-1:0]    sram_wmask0_o,
  output logic [ADDR_W-1:0]      sram_addr0_o,
  output logic [DATA_W-1:0]      sram_din0_o,
  input  logic [DATA_W-1:0]      sram_dout0_i
);

  localparam int BE_W = DATA_W / 8;

  // Read-owner encoding: who performed a read in the previous cycle.
  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_CORE = 2'd1;
  localparam logic [1:0] RD_WB   = 2'd2;

  logic       run;
  logic       last_wb;
  logic       wb_ack_q;
  logic       core_rv_q;
  logic [1:0] rd_owner;

  logic wb_req;
  logic cr_req;
  logic gnt_wb;
  logic gnt_cr;

  // Byte-offset bits of the Wishbone address carry no information here.
  logic unused_adr_bits;
  assign unused_adr_bits = ^wbs_adr_i[1:0];

  // Wishbone is blocked during its own ack cycle so a master still holding
  // stb for the acknowledged transfer is not served twice.
  assign wb_req = run & wbs_cyc_i & wbs_stb_i & ~wb_ack_q;
  assign cr_req = run & core_req_i;

  // last_wb = 1 means Wishbone won last time, so the core wins a conflict.
  assign gnt_wb = wb_req & (~cr_req | ~last_wb);
  assign gnt_cr = cr_req & ~gnt_wb;

  assign core_gnt_o = gnt_cr;

  // SRAM drive. When Wishbone is not granted the core's fields are presented
  // so idle cycles stay stable; run gates everything to the reset values.
  always_comb begin
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b1;
    sram_wmask0_o = '0;
    sram_addr0_o  = '0;
    sram_din0_o   = '0;
    if (run) begin
      sram_csb0_o = ~(gnt_wb | gnt_cr);
      if (gnt_wb) begin
        sram_web0_o   = ~wbs_we_i;
        sram_wmask0_o = wbs_we_i ? wbs_sel_i : {BE_W{1'b1}};
        sram_addr0_o  = wbs_adr_i[ADDR_W+1:2];
        sram_din0_o   = wbs_dat_i;
      end else begin
        sram_web0_o   = ~(gnt_cr & core_we_i);
        sram_wmask0_o = core_we_i ? core_be_i : {BE_W{1'b1}};
        sram_addr0_o  = core_addr_i;
        sram_din0_o   = core_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      run       <= 1'b0;
      last_wb   <= 1'b1;
      wb_ack_q  <= 1'b0;
      core_rv_q <= 1'b0;
      rd_owner  <= RD_NONE;
    end else begin
      run       <= 1'b1;
      wb_ack_q  <= gnt_wb;
      core_rv_q <= gnt_cr;
      if (gnt_wb) begin
        last_wb <= 1'b1;
      end else if (gnt_cr) begin
        last_wb <= 1'b0;
      end
      if (gnt_wb && !wbs_we_i) begin
        rd_owner <= RD_WB;
      end else if (gnt_cr && !core_we_i) begin
        rd_owner <= RD_CORE;
      end else begin
        rd_owner <= RD_NONE;
      end
    end
  end

  assign core_rvalid_o = core_rv_q;
  assign wbs_ack_o     = wb_ack_q;

  // SRAM dout is only meaningful after a read; steer it to its owner.
  assign core_rdata_o = (rd_owner == RD_CORE) ? sram_dout0_i : '0;
  assign wbs_dat_o    = (rd_owner == RD_WB)   ? sram_dout0_i : '0;

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rstn_i;

  logic              core_req_i, core_we_i;
  logic [BE_W-1:0]   core_be_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wdata_i;
  logic              core_gnt_o, core_rvalid_o;
  logic [DATA_W-1:0] core_rdata_o;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [BE_W-1:0]   wbs_sel_i;
  logic [ADDR_W+1:0] wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic              wbs_ack_o;
  logic [DATA_W-1:0] wbs_dat_o;
  logic              sram_csb0_o, sram_web0_o;
  logic [BE_W-1:0]   sram_wmask0_o;
  logic [ADDR_W-1:0] sram_addr0_o;
  logic [DATA_W-1:0] sram_din0_o;
  logic [DATA_W-1:0] sram_dout0_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .sram_csb0_o(sram_csb0_o), .sram_web0_o(sram_web0_o), .sram_wmask0_o(sram_wmask0_o),
    .sram_addr0_o(sram_addr0_o), .sram_din0_o(sram_din0_o), .sram_dout0_i(sram_dout0_i)
  );

  // ---------------- SRAM model (registered read, byte-masked write) ----------------
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk_i) begin
    if (!sram_csb0_o) begin
      if (!sram_web0_o) begin
        for (int b = 0; b < BE_W; b++) begin
          if (sram_wmask0_o[b]) mem[sram_addr0_o][b*8 +: 8] <= sram_din0_o[b*8 +: 8];
        end
      end else begin
        sram_dout0_i <= mem[sram_addr0_o];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    core_req_i = 1'b0; core_we_i = 1'b0; core_be_i = '0; core_addr_i = '0; core_wdata_i = '0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
  endtask

  task automatic wb_write_drv(input logic [ADDR_W+1:0] adr, input logic [DATA_W-1:0] dat);
    bit got;
    got = 1'b0;
    @(negedge clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = adr; wbs_dat_i = dat;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (wbs_ack_o === 1'b1) begin got = 1'b1; break; end
    end
    @(negedge clk_i);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL wb_write_timeout adr=%h got no ack, required ack within 4 cycles", adr);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn_i = 1'b0;
    // Requests during reset must not reach the SRAM.
    core_req_i = 1'b1; core_we_i = 1'b1; core_be_i = 4'hF; core_addr_i = 8'h5A; core_wdata_i = 32'hDEADBEEF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF; wbs_adr_i = 10'h3FC; wbs_dat_i = 32'h12345678;
    repeat (2) @(negedge clk_i);
    #1;
    n_cmp++; if (core_gnt_o !== 1'b0) begin n_err++; $display("FAIL rst_gnt got %b need 0", core_gnt_o); end
    n_cmp++; if (core_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got %b need 0", core_rvalid_o); end
    n_cmp++; if (wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack got %b need 0", wbs_ack_o); end
    n_cmp++; if (sram_csb0_o !== 1'b1) begin n_err++; $display("FAIL rst_csb got %b need 1", sram_csb0_o); end
    n_cmp++; if (sram_web0_o !== 1'b1) begin n_err++; $display("FAIL rst_web got %b need 1", sram_web0_o); end
    n_cmp++; if (sram_wmask0_o !== 4'h0) begin n_err++; $display("FAIL rst_wmask got %h need 0", sram_wmask0_o); end
    n_cmp++; if (sram_addr0_o !== 8'h00) begin n_err++; $display("FAIL rst_addr got %h need 0", sram_addr0_o); end
    n_cmp++; if (sram_din0_o !== 32'h0) begin n_err++; $display("FAIL rst_din got %h need 0", sram_din0_o); end
    idle_inputs();
    @(negedge clk_i); rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_conflict();
    logic exp_gnt, exp_ack, exp_rv;
    logic [ADDR_W-1:0] exp_addr;
    @(negedge clk_i); rstn_i = 1'b0;
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b1; core_be_i = 4'hF; core_addr_i = 8'h30; core_wdata_i = 32'h0000C0DE;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF; wbs_adr_i = {8'h31, 2'b00}; wbs_dat_i = 32'h00000B0B;
    rstn_i = 1'b1;
    #1;
    // First cycle after release: run not yet set, nothing granted.
    n_cmp++; if (core_gnt_o !== 1'b0 || sram_csb0_o !== 1'b1) begin
      n_err++; $display("FAIL conf_run_gate gnt=%b csb=%b need gnt=0 csb=1", core_gnt_o, sram_csb0_o);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i); #1;
      exp_gnt  = (k % 2 == 1);
      exp_ack  = (k >= 3) && (k % 2 == 1);
      exp_rv   = (k >= 2) && (k % 2 == 0);
      exp_addr = (k % 2 == 1) ? 8'h30 : 8'h31;
      n_cmp++; if (core_gnt_o !== exp_gnt) begin n_err++; $display("FAIL conf_gnt c%0d got %b need %b", k, core_gnt_o, exp_gnt); end
      n_cmp++; if (wbs_ack_o !== exp_ack) begin n_err++; $display("FAIL conf_ack c%0d got %b need %b", k, wbs_ack_o, exp_ack); end
      n_cmp++; if (core_rvalid_o !== exp_rv) begin n_err++; $display("FAIL conf_rvalid c%0d got %b need %b", k, core_rvalid_o, exp_rv); end
      n_cmp++; if (sram_csb0_o !== 1'b0) begin n_err++; $display("FAIL conf_csb c%0d got %b need 0", k, sram_csb0_o); end
      n_cmp++; if (sram_addr0_o !== exp_addr) begin n_err++; $display("FAIL conf_addr c%0d got %h need %h", k, sram_addr0_o, exp_addr); end
    end
    @(negedge clk_i); idle_inputs();
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_wb_write();
    @(negedge clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = 10'h000; wbs_dat_i = 32'hAB610000;
    #1;
    n_cmp++; if (sram_csb0_o !== 1'b0 || sram_web0_o !== 1'b0) begin
      n_err++; $display("FAIL wbw_ctl csb=%b web=%b need 0 0", sram_csb0_o, sram_web0_o);
    end
    n_cmp++; if (sram_addr0_o !== 8'h00) begin n_err++; $display("FAIL wbw_addr got %h need 00", sram_addr0_o); end
    n_cmp++; if (sram_din0_o !== 32'hAB610000) begin n_err++; $display("FAIL wbw_din got %h need ab610000", sram_din0_o); end
    n_cmp++; if (sram_wmask0_o !== 4'hF) begin n_err++; $display("FAIL wbw_wmask got %h need f", sram_wmask0_o); end
    n_cmp++; if (wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL wbw_ack_early got %b need 0", wbs_ack_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (wbs_ack_o !== 1'b1) begin n_err++; $display("FAIL wbw_ack got %b need 1", wbs_ack_o); end
    // Master immediately presents a read of the same address.
    @(negedge clk_i); wbs_we_i = 1'b0; #1;
    n_cmp++; if (sram_csb0_o !== 1'b1) begin n_err++; $display("FAIL wb_no_regrant csb=%b need 1", sram_csb0_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL wbw_ack_width got %b need 0", wbs_ack_o); end
    @(negedge clk_i); #1;
    n_cmp++; if (sram_csb0_o !== 1'b0 || sram_web0_o !== 1'b1) begin
      n_err++; $display("FAIL wbr_ctl csb=%b web=%b need 0 1", sram_csb0_o, sram_web0_o);
    end
    @(posedge clk_i); #1;
    n_cmp++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'hAB610000) begin
      n_err++; $display("FAIL wb_raw ack=%b dat=%h need 1 ab610000", wbs_ack_o, wbs_dat_o);
    end
    @(negedge clk_i); idle_inputs();
    @(posedge clk_i); #1;
    n_cmp++; if (wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL wbr_ack_width got %b need 0", wbs_ack_o); end
  endtask

  task automatic test_core_read();
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 8'h00;
    #1;
    n_cmp++; if (core_gnt_o !== 1'b1) begin n_err++; $display("FAIL crd_gnt got %b need 1", core_gnt_o); end
    n_cmp++; if (sram_web0_o !== 1'b1 || sram_wmask0_o !== 4'hF) begin
      n_err++; $display("FAIL crd_ctl web=%b wmask=%h need 1 f", sram_web0_o, sram_wmask0_o);
    end
    @(posedge clk_i); #1;
    n_cmp++; if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'hAB610000) begin
      n_err++; $display("FAIL crd_data rvalid=%b rdata=%h need 1 ab610000", core_rvalid_o, core_rdata_o);
    end
    @(negedge clk_i); idle_inputs();
    @(posedge clk_i); #1;
    n_cmp++; if (core_rvalid_o !== 1'b0) begin n_err++; $display("FAIL crd_rvalid_width got %b need 0", core_rvalid_o); end
  endtask

  task automatic test_byte_write();
    wb_write_drv(10'h014, 32'h11223344);
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b1; core_be_i = 4'b0100; core_addr_i = 8'h05; core_wdata_i = 32'h00CD0000;
    #1;
    n_cmp++; if (core_gnt_o !== 1'b1 || sram_web0_o !== 1'b0) begin
      n_err++; $display("FAIL bw_ctl gnt=%b web=%b need 1 0", core_gnt_o, sram_web0_o);
    end
    n_cmp++; if (sram_wmask0_o !== 4'b0100) begin n_err++; $display("FAIL bw_wmask got %b need 0100", sram_wmask0_o); end
    n_cmp++; if (sram_addr0_o !== 8'h05 || sram_din0_o !== 32'h00CD0000) begin
      n_err++; $display("FAIL bw_addr_din addr=%h din=%h need 05 00cd0000", sram_addr0_o, sram_din0_o);
    end
    @(posedge clk_i); #1;
    n_cmp++; if (core_rvalid_o !== 1'b1) begin n_err++; $display("FAIL bw_rvalid got %b need 1", core_rvalid_o); end
    @(negedge clk_i); idle_inputs();
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_adr_i = 10'h014;
    #1;
    n_cmp++; if (sram_addr0_o !== 8'h05 || sram_wmask0_o !== 4'hF) begin
      n_err++; $display("FAIL bw_rd_addr addr=%h wmask=%h need 05 f", sram_addr0_o, sram_wmask0_o);
    end
    @(posedge clk_i); #1;
    n_cmp++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h11CD3344) begin
      n_err++; $display("FAIL bw_merge ack=%b dat=%h need 1 11cd3344", wbs_ack_o, wbs_dat_o);
    end
    @(negedge clk_i); idle_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_d;
    for (int i = 1; i <= 3; i++) wb_write_drv(10'(i * 4), 32'hB0B00000 | 32'(i));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 8'(i);
      #1;
      n_cmp++; if (core_gnt_o !== 1'b1) begin n_err++; $display("FAIL b2b_gnt %0d got %b need 1", i, core_gnt_o); end
      exp_q.push_back(32'hB0B00000 | 32'(i));
      @(posedge clk_i); #1;
      n_cmp++;
      if (core_rvalid_o !== 1'b1 || exp_q.size() == 0) begin
        n_err++; $display("FAIL b2b_rvalid %0d got %b need 1", i, core_rvalid_o);
      end else begin
        exp_d = exp_q.pop_front();
        if (core_rdata_o !== exp_d) begin
          n_err++; $display("FAIL b2b_rdata %0d got %h need %h", i, core_rdata_o, exp_d);
        end
      end
    end
    @(negedge clk_i); idle_inputs();
    @(posedge clk_i); #1;
    n_cmp++; if (core_rvalid_o !== 1'b0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_drain rvalid=%b pending=%0d need 0 0", core_rvalid_o, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_adr_i = 10'h008;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 8'h03;
    #1;
    // Core won last, so Wishbone takes this conflict.
    n_cmp++; if (core_gnt_o !== 1'b0 || sram_csb0_o !== 1'b0 || sram_addr0_o !== 8'h02) begin
      n_err++; $display("FAIL rm_wb_grant gnt=%b csb=%b addr=%h need 0 0 02", core_gnt_o, sram_csb0_o, sram_addr0_o);
    end
    @(posedge clk_i); #1;
    n_cmp++; if (wbs_ack_o !== 1'b1) begin n_err++; $display("FAIL rm_ack_pre got %b need 1", wbs_ack_o); end
    rstn_i = 1'b0;
    #1;
    n_cmp++; if (wbs_ack_o !== 1'b0 || sram_csb0_o !== 1'b1) begin
      n_err++; $display("FAIL rm_async ack=%b csb=%b need 0 1", wbs_ack_o, sram_csb0_o);
    end
    n_cmp++; if (core_gnt_o !== 1'b0) begin n_err++; $display("FAIL rm_gnt_in_rst got %b need 0", core_gnt_o); end
    @(negedge clk_i);
    @(negedge clk_i); rstn_i = 1'b1;
    #1;
    n_cmp++; if (wbs_ack_o !== 1'b0 || core_gnt_o !== 1'b0) begin
      n_err++; $display("FAIL rm_rel_c0 ack=%b gnt=%b need 0 0", wbs_ack_o, core_gnt_o);
    end
    @(negedge clk_i); #1;
    n_cmp++; if (wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL rm_spurious_ack got %b need 0", wbs_ack_o); end
    n_cmp++; if (core_gnt_o !== 1'b1 || sram_addr0_o !== 8'h03) begin
      n_err++; $display("FAIL rm_first_conflict gnt=%b addr=%h need 1 03", core_gnt_o, sram_addr0_o);
    end
    @(negedge clk_i); idle_inputs();
    repeat (2) @(negedge clk_i);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_inputs();
    rstn_i = 1'b0;
    test_reset();
    test_conflict();
    test_wb_write();
    test_core_read();
    test_byte_write();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout simulation exceeded 50000 time units");
    $fatal(1);
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares port 0 (1RW) of the user-project data SRAM (OpenRAM macro, 32x256) between two requesters: the rvj1 core data port (OBI-style) and the Caravel Wishbone slave port.
- Management SoC firmware can preload and inspect data memory while the core runs.
- Drives SRAM signals csb0, web0, wmask0, addr0, din0 and consumes dout0.
- Round-robin on conflict; one SRAM access per cycle.

Parameters:
- ADDR_W, 8, SRAM word-address width (256 words).
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable and wmask width (derived, not overridable).

Ports:
- clk_i  in  1  system clock; SRAM clk0 uses the same clock.
- rstn_i  in  1  asynchronous active-low reset.
- core_req_i  in  1  core data request.
- core_we_i  in  1  1 = write.
- core_be_i  in  BE_W  byte enables.
- core_addr_i  in  ADDR_W  word address.
- core_wdata_i  in  DATA_W  write data.
- core_gnt_o  out  1  request accepted this cycle (combinational).
- core_rvalid_o  out  1  response valid (read data or write done).
- core_rdata_o  out  DATA_W  read data.
- wbs_cyc_i, wbs_stb_i  in  1  Wishbone classic cycle/strobe, already address-decoded upstream.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  BE_W  byte selects.
- wbs_adr_i  in  ADDR_W+2  byte address; bits [1:0] ignored.
- wbs_dat_i  in  DATA_W  write data.
- wbs_ack_o  out  1  Wishbone ack.
- wbs_dat_o  out  DATA_W  Wishbone read data.
- sram_csb0_o  out  1  chip select, active low.
- sram_web0_o  out  1  write enable, active low.
- sram_wmask0_o  out  BE_W  byte write mask.
- sram_addr0_o  out  ADDR_W  word address.
- sram_din0_o  out  DATA_W  write data.
- sram_dout0_i  in  DATA_W  read data, valid the cycle after the access.

Behaviour:
- Registered state:
  - run: cleared by reset, set on the first clock edge after reset release.
  - last_wb: round-robin pointer, 1 = Wishbone was the last requester granted.
  - wb_ack_q.
  - core_rv_q.
  - rd_owner: records which requester, if any, performed a read last cycle.
- Reset values, all outputs while rstn_i = 0:
  - core_gnt_o = 0, core_rvalid_o = 0, wbs_ack_o = 0.
  - sram_csb0_o = 1, sram_web0_o = 1, wmask = 0, addr = 0, din = 0.
  - last_wb = 1, so the core wins the first conflict.
- Request definitions:
  - wb_req = run & wbs_cyc_i & wbs_stb_i & ~wb_ack_q. Wishbone is never re-granted in its ack cycle.
  - cr_req = run & core_req_i.
- Grant rules, combinational, evaluated each cycle:
  - Only one requester: it is granted.
  - Both requesting: grant the Wishbone side if last_wb = 0, otherwise the core.
  - last_wb updates to the winner on every granted cycle.
  - No request: last_wb holds.
- SRAM drive in the grant cycle:
  - sram_csb0_o = 0.
  - sram_web0_o = ~we.
  - sram_wmask0_o = be/sel for writes, all-ones for reads.
  - sram_addr0_o = core_addr_i, or wbs_adr_i[ADDR_W+1:2] for Wishbone.
  - sram_din0_o = the granted requester's write data.
  - Idle cycle: csb0 = 1, web0 = 1; other SRAM outputs are don't-care but stable (hold the core's fields).
- Core timing:
  - core_gnt_o = 1 in the grant cycle.
  - core_rvalid_o = 1 exactly one cycle later, for both reads and writes.
  - For reads, core_rdata_o = sram_dout0_i in that cycle; otherwise it is don't-care.
  - Back-to-back core grants give back-to-back rvalids (throughput 1/cycle).
- Wishbone timing:
  - wbs_ack_o = 1 for exactly one cycle, the cycle after the grant (latency 1 cycle from grant).
  - For reads, wbs_dat_o = sram_dout0_i in the ack cycle.
  - A Wishbone write followed immediately by the same address's read sees the new data.
  - A master that drops stb before its grant is not served and gets no ack.
- Conflict behaviour:
  - The loser holds its request; it is served next cycle at the latest.
  - Worst-case wait per requester is 1 cycle.
- Simultaneous same-address accesses are serialized; no merging.
- Address aliasing: Wishbone address bits above ADDR_W+1 are not present; decode is upstream.
- Reset asserted mid-operation:
  - All pending rvalid/ack are dropped immediately (async).
  - sram_csb0_o = 1 at once.
  - No ack is issued after reset release for accesses in flight.

Test Plan:
- Reset, then Wishbone write sel=4'hF, adr=0x000, dat=0xAB610000 -> sram_addr0_o=0, sram_din0_o=0xAB610000, web0=0, csb0=0 in the grant cycle; ack one cycle later; ack low the cycle after.
- Core read, addr 0x00, after the above write -> gnt same cycle; rvalid next cycle with rdata=0xAB610000.
- Core and Wishbone request continuously from the first cycle after reset -> grants alternate core, WB, core, WB, ...; every WB ack is 1 cycle wide; no grant is lost.
- Core byte write be=4'b0100, addr 0x05, wdata=0x00CD0000 over existing 0x11223344 -> wmask=4'b0100; a subsequent Wishbone read of adr 0x014 returns 0x11CD3344.
- Core back-to-back reads of addr 1,2,3 with no Wishbone traffic -> gnt on 3 consecutive cycles; rvalid on the next 3 consecutive cycles with the matching data.
- Assert rstn_i low the cycle after a Wishbone read grant -> wbs_ack_o=0 immediately and csb0=1; after release, no spurious ack and the first conflict goes to the core.
